stopwatch_ctrl: RTL



---
 rtl/stopwatch_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, run/pause/clear FSM and seconds-tick prescaler.
// Optional macro STOPWATCH_AUTOSTOP_EN adds a DONE state entered when 59:59 is ticked.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic [3:0] min_tens_i,
  input  logic [3:0] min_units_i,
  input  logic [3:0] sec_tens_i,
  input  logic [3:0] sec_units_i,
  output logic       tick_o,
  output logic       clr_o,
  output logic       running_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LP_TOP = CNT_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_ss_sync;   // [0]=s1, [1]=s2, [2]=s3 (edge history)
  logic [2:0]       r_clr_sync;
  logic [CNT_W-1:0] r_presc;
  logic             r_tick;
  logic             r_clr;
  logic             w_ss_edge;
  logic             w_clr_edge;
  logic             w_at_top;
  logic             w_count;
  logic             w_tick;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ss_sync  <= '0;
      r_clr_sync <= '0;
    end else begin
      r_ss_sync  <= {r_ss_sync[1:0], btn_start_stop};
      r_clr_sync <= {r_clr_sync[1:0], btn_clear};
    end
  end

  assign w_ss_edge  = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_clr_edge = r_clr_sync[1] & ~r_clr_sync[2];
  assign w_at_top   = (r_presc == LP_TOP);

`ifdef STOPWATCH_AUTOSTOP_EN
  logic w_at_limit;
  assign w_at_limit = (min_tens_i == 4'd5) && (min_units_i == 4'd9) &&
                      (sec_tens_i == 4'd5) && (sec_units_i == 4'd9);
`else
  logic w_unused_digits;
  assign w_unused_digits = ^{min_tens_i, min_units_i, sec_tens_i, sec_units_i};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next  = r_state;
    w_count = 1'b0;
    w_tick  = 1'b0;
    if (w_clr_edge) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_ss_edge) w_next = S_RUN;
        S_RUN: begin
          // Leaving RUN freezes the prescaler, so a tick due on this edge is dropped.
          if (w_ss_edge) begin
            w_next = S_PAUSE;
          end else begin
            w_count = 1'b1;
            if (w_at_top) begin
              w_tick = 1'b1;
`ifdef STOPWATCH_AUTOSTOP_EN
              if (w_at_limit) w_next = S_DONE;
`endif
            end
          end
        end
        S_PAUSE: if (w_ss_edge) w_next = S_RUN;
        S_DONE: begin
`ifdef STOPWATCH_AUTOSTOP_EN
          w_next = S_DONE;
`else
          w_next = S_IDLE;
`endif
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_count) begin
      r_presc <= w_at_top ? '0 : r_presc + CNT_W'(1);
    end else if (w_next == S_IDLE || w_next == S_DONE) begin
      r_presc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick <= 1'b0;
      r_clr  <= 1'b0;
    end else begin
      r_clr  <= w_clr_edge;
      r_tick <= w_tick & ~w_clr_edge;
    end
  end

  assign tick_o    = r_tick;
  assign clr_o     = r_clr;
  assign running_o = (r_state == S_RUN);
  assign state_o   = r_state;

endmodule
